router_reg_param: RTL and testbench
===================================

// Module: router_reg_param
// PURPOSE
//   Parametrised packet register for the 1xN router datapath. Sits between the router
//   input port and the FIFO bank: latches the header, forwards header and payload to the FIFOs,
//   and holds one byte while a FIFO is full.
//   Accumulates a running check value and compares it with the trailing check byte.
//   Adds, beyond the 8-bit/3-channel block: configurable data width and channel count,
//   selectable XOR or additive checksum, and a payload length check.
// PARAMETERS
//   DATA_W      8   data byte width; header = {len[DATA_W-1:ADDR_W], addr[ADDR_W-1:0]}
//   ADDR_W      2   header address field width
//   NUM_CH      3   valid channels; header addr >= NUM_CH is invalid (not latched)
//   CHK_MODE    0   0 = XOR of header+payload; 1 = sum mod 2^DATA_W of header+payload
//   LEN_CHECK   1   1 = compare accepted payload count with header len; 0 = len_err tied 0
// PORTS
//   clk              in   1       rising-edge clock
//   reset            in   1       synchronous, active-high reset
//   packet_valid     in   1       source drives header/payload bytes; drops for the check byte
//   datain           in   DATA_W  input byte
//   fifo_full        in   1       selected FIFO full
//   detect_add       in   1       FSM in header-detect state
//   lfd_state        in   1       FSM loading first byte (header)
//   ld_state         in   1       FSM loading data
//   laf_state        in   1       FSM loading the byte held during fifo_full
//   full_state       in   1       FSM in FIFO-full wait
//   rst_int_reg      in   1       FSM clears low_packet_valid
//   dout             out  DATA_W  byte to FIFO bank
//   parity_done      out  1       check byte captured
//   low_packet_valid out  1       packet_valid dropped during ld_state
//   err              out  1       check mismatch
//   len_err          out  1       payload count != header len
// BEHAVIOUR
//   Reset (reset=1 at posedge): dout, hold, header, calc, pkt_chk, byte_cnt and all flags go to 0.
//     Reset overrides every other input, including mid-packet.
//   Header: detect_add & packet_valid & addr<NUM_CH -> header<=datain; otherwise header holds.
//   dout: lfd_state -> header; ld_state & !fifo_full & packet_valid -> datain;
//     ld_state & !fifo_full & !packet_valid -> datain (the check byte is forwarded);
//     ld_state & fifo_full -> hold<=datain, dout holds; laf_state -> hold; otherwise dout holds.
//   calc: detect_add -> 0. lfd_state -> calc op header.
//     ld_state & packet_valid & !full_state -> calc op datain.
//     op = XOR (CHK_MODE 0) or + with DATA_W-bit wrap (CHK_MODE 1).
//   byte_cnt (DATA_W-ADDR_W bits): detect_add -> 0.
//     Increments on the same condition as the calc payload update and saturates at all-ones.
//   pkt_chk / parity_done: ld_state & !packet_valid & !fifo_full, or
//     laf_state & low_packet_valid & !parity_done -> pkt_chk<=datain (laf: hold), parity_done<=1.
//     detect_add -> parity_done<=0. Otherwise parity_done holds.
//   low_packet_valid: ld_state & !packet_valid -> 1; rst_int_reg -> 0.
//     If both are true in the same cycle, rst_int_reg wins.
//   err / len_err: update one cycle after parity_done rises (parity_done==1 and not yet evaluated).
//     err <= (calc != pkt_chk); len_err <= LEN_CHECK & (byte_cnt != header len).
//     Both hold until detect_add clears them. Latency is check byte -> err: 2 clocks.
//   Simultaneous detect_add and ld_state: detect_add clears take priority for calc, byte_cnt and flags.
//   Zero-length header: len=0 is legal; err compares against header-only calc.
// TESTING
//   T1 CHK_MODE0: header 0x22, payload 0x01..0x08, check 0x2A
//      -> dout=0x22 then 0x01..0x08, parity_done=1, err=0, len_err=0.
//   T2 CHK_MODE0: same packet, check 0xD5 -> err=1 two clocks after check byte; cleared by next detect_add.
//   T3 CHK_MODE1: header 0x22, payload 0x01..0x08, check 0x46 -> err=0; check 0x2A -> err=1.
//   T4 fifo_full high during payload byte 0x05 -> dout holds 0x04; laf_state -> dout=0x05;
//      final err=0.
//   T5 header len=8, only 7 payload bytes sent -> len_err=1, err=1 for check computed over 8 bytes.
//   T6 reset=1 mid-payload -> all outputs 0 next edge; header addr 0x3 (NUM_CH=3) not latched.

Source files
------------

// File: rtl/router_reg_param.sv
// Packet register between the router input port and the FIFO bank: latches the header,
// forwards bytes, parks one byte across a FIFO-full stall and checks the packet trailer.
module router_reg_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 2,
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned CHK_MODE  = 0,
    parameter bit          LEN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              packet_valid,
    input  logic [DATA_W-1:0] datain,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic [DATA_W-1:0] dout,
    output logic              parity_done,
    output logic              low_packet_valid,
    output logic              err,
    output logic              len_err
);

    localparam int unsigned LEN_W = DATA_W - ADDR_W;

    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] header_q, header_d;
    logic [DATA_W-1:0] calc_q, calc_d;
    logic [DATA_W-1:0] pkt_chk_q, pkt_chk_d;
    logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic              parity_done_q, parity_done_d;
    logic              low_pv_q, low_pv_d;
    logic              err_q, err_d;
    logic              len_err_q, len_err_d;
    logic              evaluated_q, evaluated_d;

    logic addr_ok;
    logic payload_upd;

    function automatic logic [DATA_W-1:0] chk_op(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        if (CHK_MODE == 1) begin
            return a + b;
        end
        return a ^ b;
    endfunction

    assign addr_ok     = 32'(datain[ADDR_W-1:0]) < NUM_CH;
    assign payload_upd = ld_state && packet_valid && !full_state;

    always_comb begin
        header_d      = header_q;
        dout_d        = dout_q;
        hold_d        = hold_q;
        calc_d        = calc_q;
        byte_cnt_d    = byte_cnt_q;
        pkt_chk_d     = pkt_chk_q;
        parity_done_d = parity_done_q;
        low_pv_d      = low_pv_q;
        err_d         = err_q;
        len_err_d     = len_err_q;
        evaluated_d   = evaluated_q;

        if (detect_add && packet_valid && addr_ok) begin
            header_d = datain;
        end

        // The check byte is forwarded too; a byte arriving while full is parked in hold.
        if (lfd_state) begin
            dout_d = header_q;
        end else if (ld_state && !fifo_full) begin
            dout_d = datain;
        end else if (ld_state && fifo_full) begin
            hold_d = datain;
        end else if (laf_state) begin
            dout_d = hold_q;
        end

        if (detect_add) begin
            calc_d     = '0;
            byte_cnt_d = '0;
        end else if (lfd_state) begin
            calc_d = chk_op(calc_q, header_q);
        end else if (payload_upd) begin
            calc_d = chk_op(calc_q, datain);
            if (byte_cnt_q != '1) begin
                byte_cnt_d = byte_cnt_q + LEN_W'(1);
            end
        end

        if (detect_add) begin
            parity_done_d = 1'b0;
        end else if (ld_state && !packet_valid && !fifo_full) begin
            pkt_chk_d     = datain;
            parity_done_d = 1'b1;
        end else if (laf_state && low_pv_q && !parity_done_q) begin
            pkt_chk_d     = hold_q;
            parity_done_d = 1'b1;
        end

        if (rst_int_reg) begin
            low_pv_d = 1'b0;
        end else if (ld_state && !packet_valid) begin
            low_pv_d = 1'b1;
        end

        // Evaluate once, the cycle after the check byte is captured.
        if (detect_add) begin
            err_d       = 1'b0;
            len_err_d   = 1'b0;
            evaluated_d = 1'b0;
        end else if (parity_done_q && !evaluated_q) begin
            err_d       = calc_q != pkt_chk_q;
            len_err_d   = LEN_CHECK && (byte_cnt_q != header_q[DATA_W-1:ADDR_W]);
            evaluated_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q        <= '0;
            hold_q        <= '0;
            header_q      <= '0;
            calc_q        <= '0;
            pkt_chk_q     <= '0;
            byte_cnt_q    <= '0;
            parity_done_q <= 1'b0;
            low_pv_q      <= 1'b0;
            err_q         <= 1'b0;
            len_err_q     <= 1'b0;
            evaluated_q   <= 1'b0;
        end else begin
            dout_q        <= dout_d;
            hold_q        <= hold_d;
            header_q      <= header_d;
            calc_q        <= calc_d;
            pkt_chk_q     <= pkt_chk_d;
            byte_cnt_q    <= byte_cnt_d;
            parity_done_q <= parity_done_d;
            low_pv_q      <= low_pv_d;
            err_q         <= err_d;
            len_err_q     <= len_err_d;
            evaluated_q   <= evaluated_d;
        end
    end

    assign dout             = dout_q;
    assign parity_done      = parity_done_q;
    assign low_packet_valid = low_pv_q;
    assign err              = err_q;
    assign len_err          = len_err_q;

endmodule

// File: tb/tb_router_reg_param.sv
// Scoreboard bench for router_reg_param: an XOR-checksum and an additive-checksum instance
// share one stimulus stream; expected bytes and check results are queued as packets are driven.
module tb_router_reg_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, packet_valid, fifo_full, detect_add, lfd_state, ld_state;
    logic       laf_state, full_state, rst_int_reg;
    logic [7:0] datain;
    logic [7:0] dout0, dout1;
    logic       pd0, pd1, lpv0, lpv1, err0, err1, lerr0, lerr1;

    router_reg_param #(.CHK_MODE(0)) u_dut0 (
        .clk(clk), .reset(reset), .packet_valid(packet_valid), .datain(datain),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .dout(dout0), .parity_done(pd0),
        .low_packet_valid(lpv0), .err(err0), .len_err(lerr0)
    );

    router_reg_param #(.CHK_MODE(1)) u_dut1 (
        .clk(clk), .reset(reset), .packet_valid(packet_valid), .datain(datain),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .dout(dout1), .parity_done(pd1),
        .low_packet_valid(lpv1), .err(err1), .len_err(lerr1)
    );

    typedef struct {
        logic e0;
        logic e1;
        logic le;
    } res_t;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    res_t       res_q[$];
    logic [7:0] pay[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        packet_valid = 1'b0; fifo_full = 1'b0; detect_add = 1'b0; lfd_state = 1'b0;
        ld_state = 1'b0; laf_state = 1'b0; full_state = 1'b0; rst_int_reg = 1'b0;
        datain = 8'h00;
    endtask

    task automatic pop_dout(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val({tag, "_dout0"}, {24'd0, dout0}, {24'd0, e});
            check_val({tag, "_dout1"}, {24'd0, dout1}, {24'd0, e});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_dout0"}, {24'd0, dout0}, 32'd0);
        check_val({tag, "_dout1"}, {24'd0, dout1}, 32'd0);
        check_val({tag, "_flags0"}, {28'd0, pd0, lpv0, err0, lerr0}, 32'd0);
        check_val({tag, "_flags1"}, {28'd0, pd1, lpv1, err1, lerr1}, 32'd0);
    endtask

    // Sends hdr + pay + chk; the payload byte at full_idx meets fifo_full (-1: never).
    task automatic send_packet(input string tag, input logic [7:0] hdr, input logic [7:0] chk,
                               input int full_idx);
        logic [7:0] x, s, prev;
        int         cnt;
        res_t       r;
        x = hdr;
        s = hdr;
        foreach (pay[i]) begin
            x = x ^ pay[i];
            s = s + pay[i];
        end
        cnt  = (pay.size() > 63) ? 63 : pay.size();
        r.e0 = (chk != x);
        r.e1 = (chk != s);
        r.le = (cnt != int'(hdr[7:2]));

        clear_inputs();
        detect_add = 1'b1; packet_valid = 1'b1; datain = hdr;
        step();
        check_val({tag, "_clr"}, {28'd0, pd0, pd1, err0, err1}, 32'd0);

        clear_inputs();
        lfd_state = 1'b1; packet_valid = 1'b1; datain = hdr;
        exp_q.push_back(hdr);
        step();
        pop_dout({tag, "_hdr"});
        prev = hdr;

        foreach (pay[i]) begin
            clear_inputs();
            ld_state = 1'b1; packet_valid = 1'b1; datain = pay[i];
            if (i == full_idx) begin
                fifo_full = 1'b1;
                step();
                check_val({tag, "_full_hold"}, {24'd0, dout0}, {24'd0, prev});
                clear_inputs();
                full_state = 1'b1; packet_valid = 1'b1; datain = pay[i];
                step();
                check_val({tag, "_fullst_hold"}, {24'd0, dout1}, {24'd0, prev});
                clear_inputs();
                laf_state = 1'b1; packet_valid = 1'b1; datain = pay[i];
                exp_q.push_back(pay[i]);
                step();
                pop_dout({tag, "_laf"});
            end else begin
                exp_q.push_back(pay[i]);
                step();
                pop_dout({tag, "_pay"});
            end
            prev = pay[i];
        end

        clear_inputs();
        ld_state = 1'b1; datain = chk;
        exp_q.push_back(chk);
        res_q.push_back(r);
        step();
        pop_dout({tag, "_chk"});
        check_val({tag, "_pd_lpv"}, {28'd0, pd0, pd1, lpv0, lpv1}, 32'hF);
        check_val({tag, "_err_early"}, {30'd0, err0, err1}, 32'd0);

        clear_inputs();
        rst_int_reg = 1'b1;
        step();
        r = res_q.pop_front();
        check_val({tag, "_err0"}, {31'd0, err0}, {31'd0, r.e0});
        check_val({tag, "_err1"}, {31'd0, err1}, {31'd0, r.e1});
        check_val({tag, "_lenerr"}, {30'd0, lerr0, lerr1}, {30'd0, r.le, r.le});
        check_val({tag, "_lpv_clr"}, {30'd0, lpv0, lpv1}, 32'd0);

        clear_inputs();
        step();
        check_val({tag, "_err_hold"}, {31'd0, err0}, {31'd0, r.e0});
    endtask

    task automatic load_ramp(input int n);
        pay.delete();
        for (int i = 1; i <= n; i++) pay.push_back(8'(i));
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;

        load_ramp(8);
        send_packet("t1", 8'h22, 8'h2A, -1);
        send_packet("t2", 8'h22, 8'hD5, -1);
        send_packet("t3a", 8'h22, 8'h46, -1);
        send_packet("t3b", 8'h22, 8'h2A, -1);
        send_packet("t4", 8'h22, 8'h2A, 4);
        load_ramp(7);
        send_packet("t5", 8'h22, 8'h2A, -1);

        pay.delete();
        send_packet("zlen", 8'h01, 8'h01, -1);

        pay.delete();
        for (int i = 0; i < 70; i++) pay.push_back(8'($urandom_range(0, 255)));
        send_packet("sat", 8'hFC, 8'h5A, 10);

        // Reset in the middle of a payload
        clear_inputs();
        detect_add = 1'b1; packet_valid = 1'b1; datain = 8'h22;
        step();
        clear_inputs();
        lfd_state = 1'b1; packet_valid = 1'b1;
        step();
        for (int i = 1; i <= 3; i++) begin
            clear_inputs();
            ld_state = 1'b1; packet_valid = 1'b1; datain = 8'(i);
            step();
        end
        clear_inputs();
        ld_state = 1'b1; packet_valid = 1'b1; datain = 8'h04; reset = 1'b1;
        step();
        check_all_zero("t6_rst");
        reset = 1'b0;

        clear_inputs();
        detect_add = 1'b1; packet_valid = 1'b1; datain = 8'h23;
        step();
        clear_inputs();
        lfd_state = 1'b1; packet_valid = 1'b1; datain = 8'h23;
        step();
        check_val("t6_badaddr", {24'd0, dout0}, 32'd0);

        load_ramp(8);
        send_packet("post", 8'h21, 8'h29, -1);

        check_val("sb_drained", exp_q.size() + res_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
